// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: spreads a framed serial stream of samples
// across NCH channel registers and publishes each complete frame atomically.
//
// state  | meaning
// HUNT   | not aligned; waiting for a sample flagged with fsync
// LOCKED | aligned; slot counter tracks position within the current frame
module tdm_demux #(
    parameter int WIDTH = 1,
    parameter int NCH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   din_valid_i,
    input  logic                   fsync_i,
    output logic [NCH*WIDTH-1:0]   ch_data_o,
    output logic                   frame_valid_o,
    output logic                   locked_o,
    output logic                   sync_err_o
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 slot_q, slot_d;
    logic [NCH-2:0][WIDTH-1:0]     shadow_q, shadow_d;
    logic [NCH*WIDTH-1:0]          ch_data_q, ch_data_d;
    logic                          frame_valid_q, frame_valid_d;
    logic                          sync_err_q, sync_err_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            ch_data_q     <= ch_data_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (din_valid_i) begin
            case (state_q)
                HUNT:    if (fsync_i) state_d = LOCKED;
                LOCKED:  if (!fsync_i && slot_q == '0) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // An fsync always restarts the frame at slot 0, whatever the current state;
    // a mid-frame fsync additionally flags the discarded partial frame.
    always_comb begin
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        ch_data_d     = ch_data_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (din_valid_i) begin
            if (fsync_i) begin
                shadow_d[0] = din_i;
                slot_d      = SW'(1);
                sync_err_d  = (state_q == LOCKED) && (slot_q != '0);
            end else if (state_q == LOCKED) begin
                if (slot_q == '0) begin
                    sync_err_d = 1'b1;
                end else if (slot_q == SW'(NCH-1)) begin
                    ch_data_d     = {din_i, shadow_q};
                    frame_valid_d = 1'b1;
                    slot_d        = '0;
                end else begin
                    for (int k = 0; k < NCH-1; k++) begin
                        if (slot_q == SW'(k)) shadow_d[k] = din_i;
                    end
                    slot_d = slot_q + SW'(1);
                end
            end
        end
    end

    assign ch_data_o     = ch_data_q;
    assign frame_valid_o = frame_valid_q;
    assign sync_err_o    = sync_err_q;
    assign locked_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: an 8-bit/4-channel instance for framing
// scenarios and a 1-bit/2-channel instance for the exhaustive narrow case.
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;

    logic [7:0]  din8;
    logic        dv8, fs8;
    logic [31:0] ch8;
    logic        fv8, lk8, se8;

    logic [0:0]  din1;
    logic        dv1, fs1;
    logic [1:0]  ch1;
    logic        fv1, lk1, se1;

    int errors = 0;
    int checks = 0;
    int fv8_n = 0, se8_n = 0, fv1_n = 0, se1_n = 0;

    tdm_demux #(.WIDTH(8), .NCH(4)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .din_i(din8), .din_valid_i(dv8),
        .fsync_i(fs8), .ch_data_o(ch8), .frame_valid_o(fv8),
        .locked_o(lk8), .sync_err_o(se8)
    );

    tdm_demux #(.WIDTH(1), .NCH(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .din_i(din1), .din_valid_i(dv1),
        .fsync_i(fs1), .ch_data_o(ch1), .frame_valid_o(fv1),
        .locked_o(lk1), .sync_err_o(se1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (fv8) fv8_n <= fv8_n + 1;
        if (se8) se8_n <= se8_n + 1;
        if (fv1) fv1_n <= fv1_n + 1;
        if (se1) se1_n <= se1_n + 1;
    end

    task automatic send8(input logic [7:0] d, input logic f);
        din8 = d; fs8 = f; dv8 = 1'b1;
        @(posedge clk); #1;
        dv8 = 1'b0; fs8 = 1'b0;
    endtask

    task automatic send1(input logic d, input logic f);
        din1 = d; fs1 = f; dv1 = 1'b1;
        @(posedge clk); #1;
        dv1 = 1'b0; fs1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int fv0, se0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ch8 !== 32'h0) begin errors++; $display("FAIL reset_ch: got %h want %h", ch8, 32'h0); end
        checks++; if ({fv8, lk8, se8} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {fv8, lk8, se8}); end
        checks++; if ({ch1, fv1, lk1, se1} !== 5'b0) begin errors++; $display("FAIL reset_narrow: got %b want 00000", {ch1, fv1, lk1, se1}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fv0 = fv8_n; se0 = se8_n;
        send8(8'h12, 1'b0); send8(8'h34, 1'b0); send8(8'h56, 1'b0);
        idle(1);
        checks++; if ((fv8_n - fv0) !== 0 || (se8_n - se0) !== 0) begin errors++; $display("FAIL hunt_quiet: got fv=%0d se=%0d want 0 0", fv8_n - fv0, se8_n - se0); end
        checks++; if (lk8 !== 1'b0) begin errors++; $display("FAIL hunt_locked: got %b want 0", lk8); end
        // Complete one frame, start another, then reset in the middle of it.
        send8(8'h11, 1'b1); send8(8'h22, 1'b0); send8(8'h33, 1'b0); send8(8'h44, 1'b0);
        send8(8'h55, 1'b1); send8(8'h66, 1'b0);
        checks++; if (ch8 !== 32'h44332211) begin errors++; $display("FAIL pre_reset_ch: got %h want %h", ch8, 32'h44332211); end
        rst_n = 1'b0;
        #1;
        checks++; if (ch8 !== 32'h0 || lk8 !== 1'b0) begin errors++; $display("FAIL midreset: got ch=%h lk=%b want 0 0", ch8, lk8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        fv0 = fv8_n; se0 = se8_n;
        send8(8'h77, 1'b0); send8(8'h88, 1'b0); send8(8'h99, 1'b0); send8(8'hAA, 1'b0);
        idle(1);
        checks++; if ((fv8_n - fv0) !== 0 || (se8_n - se0) !== 0 || ch8 !== 32'h0) begin errors++; $display("FAIL post_reset_nosync: got fv=%0d se=%0d ch=%h want 0 0 0", fv8_n - fv0, se8_n - se0, ch8); end
    endtask

    task automatic test_basic_frame;
        int fv0;
        fv0 = fv8_n;
        send8(8'hA1, 1'b1);
        checks++; if (lk8 !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b want 1", lk8); end
        send8(8'hB2, 1'b0); send8(8'hC3, 1'b0);
        checks++; if (ch8 !== 32'h0 || fv8 !== 1'b0) begin errors++; $display("FAIL partial_hidden: got ch=%h fv=%b want 0 0", ch8, fv8); end
        send8(8'hD4, 1'b0);
        checks++; if (ch8 !== 32'hD4C3B2A1 || fv8 !== 1'b1) begin errors++; $display("FAIL basic_frame1: got ch=%h fv=%b want d4c3b2a1 1", ch8, fv8); end
        send8(8'h11, 1'b1);
        checks++; if (fv8 !== 1'b0 || ch8 !== 32'hD4C3B2A1) begin errors++; $display("FAIL fv_one_cycle: got fv=%b ch=%h want 0 d4c3b2a1", fv8, ch8); end
        send8(8'h22, 1'b0); send8(8'h33, 1'b0); send8(8'h44, 1'b0);
        checks++; if (ch8 !== 32'h44332211 || fv8 !== 1'b1 || lk8 !== 1'b1) begin errors++; $display("FAIL basic_frame2: got ch=%h fv=%b lk=%b want 44332211 1 1", ch8, fv8, lk8); end
        idle(1);
        checks++; if ((fv8_n - fv0) !== 2) begin errors++; $display("FAIL basic_pulses: got %0d want 2", fv8_n - fv0); end
    endtask

    task automatic test_gapped;
        int fv0;
        logic [7:0] s [4];
        s[0] = 8'hA1; s[1] = 8'hB2; s[2] = 8'hC3; s[3] = 8'hD4;
        do_reset();
        fv0 = fv8_n;
        for (int i = 0; i < 3; i++) begin
            send8(s[i], i == 0);
            idle(3);
            checks++; if (ch8 !== 32'h0 || fv8 !== 1'b0) begin errors++; $display("FAIL gap_hold%0d: got ch=%h fv=%b want 0 0", i, ch8, fv8); end
        end
        send8(s[3], 1'b0);
        checks++; if (ch8 !== 32'hD4C3B2A1 || fv8 !== 1'b1) begin errors++; $display("FAIL gap_frame: got ch=%h fv=%b want d4c3b2a1 1", ch8, fv8); end
        idle(2);
        checks++; if ((fv8_n - fv0) !== 1) begin errors++; $display("FAIL gap_pulses: got %0d want 1", fv8_n - fv0); end
    endtask

    task automatic test_early_fsync;
        int fv0, se0;
        fv0 = fv8_n; se0 = se8_n;
        send8(8'h01, 1'b1); send8(8'h02, 1'b0);
        send8(8'h10, 1'b1);
        checks++; if (se8 !== 1'b1 || lk8 !== 1'b1 || fv8 !== 1'b0) begin errors++; $display("FAIL early_err: got se=%b lk=%b fv=%b want 1 1 0", se8, lk8, fv8); end
        send8(8'h20, 1'b0);
        checks++; if (se8 !== 1'b0) begin errors++; $display("FAIL early_err_width: got %b want 0", se8); end
        send8(8'h30, 1'b0); send8(8'h40, 1'b0);
        checks++; if (ch8 !== 32'h40302010 || fv8 !== 1'b1) begin errors++; $display("FAIL early_frame: got ch=%h fv=%b want 40302010 1", ch8, fv8); end
        idle(1);
        checks++; if ((fv8_n - fv0) !== 1 || (se8_n - se0) !== 1) begin errors++; $display("FAIL early_pulses: got fv=%0d se=%0d want 1 1", fv8_n - fv0, se8_n - se0); end
    endtask

    task automatic test_missing_fsync;
        int se0;
        send8(8'h01, 1'b1); send8(8'h02, 1'b0); send8(8'h03, 1'b0); send8(8'h04, 1'b0);
        checks++; if (ch8 !== 32'h04030201) begin errors++; $display("FAIL miss_pre: got %h want 04030201", ch8); end
        se0 = se8_n;
        send8(8'h55, 1'b0);
        checks++; if (se8 !== 1'b1 || lk8 !== 1'b0 || fv8 !== 1'b0 || ch8 !== 32'h04030201) begin errors++; $display("FAIL miss_err: got se=%b lk=%b fv=%b ch=%h want 1 0 0 04030201", se8, lk8, fv8, ch8); end
        idle(1);
        checks++; if (se8 !== 1'b0 || (se8_n - se0) !== 1) begin errors++; $display("FAIL miss_pulse: got se=%b n=%0d want 0 1", se8, se8_n - se0); end
        send8(8'hAA, 1'b1); send8(8'hBB, 1'b0); send8(8'hCC, 1'b0); send8(8'hDD, 1'b0);
        checks++; if (ch8 !== 32'hDDCCBBAA || lk8 !== 1'b1 || fv8 !== 1'b1) begin errors++; $display("FAIL miss_relock: got ch=%h lk=%b fv=%b want ddccbbaa 1 1", ch8, lk8, fv8); end
    endtask

    task automatic test_back_to_back_narrow;
        int fv0, se0;
        logic [1:0] v;
        fv0 = fv1_n; se0 = se1_n;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            send1(v[1], 1'b1);
            send1(v[0], 1'b0);
            checks++; if (ch1 !== {v[0], v[1]} || fv1 !== 1'b1) begin errors++; $display("FAIL narrow_frame%0d: got ch=%b fv=%b want %b 1", i, ch1, fv1, {v[0], v[1]}); end
        end
        idle(1);
        checks++; if ((fv1_n - fv0) !== 4 || (se1_n - se0) !== 0 || lk1 !== 1'b1) begin errors++; $display("FAIL narrow_pulses: got fv=%0d se=%0d lk=%b want 4 0 1", fv1_n - fv0, se1_n - se0, lk1); end
    endtask

    initial begin
        rst_n = 1'b1;
        din8 = '0; dv8 = 1'b0; fs8 = 1'b0;
        din1 = '0; dv1 = 1'b0; fs1 = 1'b0;
        test_reset();
        do_reset();
        test_basic_frame();
        test_gapped();
        test_early_fsync();
        test_missing_fsync();
        test_back_to_back_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
